spi1_cmd_ctl: RTL
=================

Name: spi1_cmd_ctl

Overview:
- Command sequencer behind the SPI1 target port.
- Consumes the synchronized received-byte stream and parses frames of the form: command byte, optional data byte, optional address-high and address-low bytes.
- Issues single-byte read/write requests to the system bus arbiter and holds the auto-incrementing 17-bit address pointer.
- Presents read results to the SPI transmit path.

Parameters:
- ADDR_WIDTH, 17, bus address width; bit 16 is carried in command bit 0.
- TIMEOUT_CYCLES, 255, bus-ack watchdog limit in clk_sys_i cycles; used only with SPI1_CMD_TIMEOUT_EN.

Ports:
- clk_sys_i  in  1  system clock; only clock in the block.
- reset_i  in  1  synchronous, active-high reset.
- cs_active_i  in  1  chip select asserted (level, already synchronized to clk_sys_i).
- rx_valid_i  in  1  one-cycle pulse per received byte.
- rx_data_i  in  8  received byte; valid when rx_valid_i=1.
- tx_data_o  out  8  last read result, for the SPI shifter.
- tx_valid_o  out  1  tx_data_o holds a read result from the current frame.
- bus_req_o  out  1  bus request; held until bus_ack_i.
- bus_we_o  out  1  1=write, 0=read; stable while bus_req_o=1.
- bus_addr_o  out  17  access address (the pointer register).
- bus_wr_data_o  out  8  write data.
- bus_rd_data_i  in  8  read data; valid with bus_ack_i.
- bus_ack_i  in  1  one-cycle completion pulse.
- busy_o  out  1  state other than IDLE.
- err_overrun_o  out  1  sticky; a byte arrived while a request was pending.
- err_timeout_o  out  1  sticky; watchdog expired.

Behaviour:
- Reset values: all outputs 0; address pointer 0x00000; state IDLE.
- Command byte layout: bit7 rw_n, bit6 set_addr, bits5:1 ignored, bit0 addr[16].
- States: IDLE, CMD, DATA, ADDR_HI, ADDR_LO, REQ, DRAIN.
- Frame start and command byte:
  - IDLE→CMD on cs_active_i rising. This clears tx_valid_o, err_overrun_o and err_timeout_o.
  - In CMD, the first rx_valid_i latches rw_n, set_addr and addr[16].
  - Next state from CMD: write goes to DATA; read with set_addr=1 goes to ADDR_HI; read with set_addr=0 goes to REQ.
- Write path:
  - DATA latches bus_wr_data_o.
  - Then set_addr=1 goes to ADDR_HI; set_addr=0 goes to REQ.
- Address bytes:
  - ADDR_HI latches addr[15:8] into a staging register.
  - ADDR_LO latches addr[7:0], loads the pointer {addr16, hi, lo}, then goes to REQ.
- Request timing:
  - bus_req_o rises in the cycle after the final byte's rx_valid_i.
  - It falls in the cycle after bus_ack_i.
- Completion on bus_ack_i:
  - Pointer increments modulo 2^17 (0x1FFFF wraps to 0x00000).
  - On a read: tx_data_o ← bus_rd_data_i and tx_valid_o ← 1.
  - Next state is DRAIN.
- DRAIN ignores further bytes. Leaves for IDLE when cs_active_i=0.
- cs_active_i falling:
  - In CMD, DATA, ADDR_HI or ADDR_LO: abort. Pointer unchanged, no request issued, go to IDLE.
  - In REQ: the request is not withdrawn. It completes normally, then goes to IDLE.
- rx_valid_i while in REQ: byte dropped; err_overrun_o ← 1.
- rx_valid_i and a cs_active_i fall in the same cycle: the byte is ignored.
- Reset mid-operation: bus_req_o drops in the next cycle. The arbiter must tolerate a dropped request.

Optional Feature:
- Macro: SPI1_CMD_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs while in REQ.
  - If it reaches TIMEOUT_CYCLES without bus_ack_i: bus_req_o drops, err_timeout_o ← 1, go to DRAIN.
  - Pointer is not incremented; tx_valid_o is not set.
- Undefined: no counter; REQ waits indefinitely; err_timeout_o tied 0.

Decomposition:
- Shared package spi1_pkg holds:
  - command bit indices (CMD_RW_N_BIT=7, CMD_SET_ADDR_BIT=6, CMD_A16_BIT=0);
  - ADDR_WIDTH;
  - the state enum;
  - the PET I/O register constant 0x0E80F (CPU control: bit1 ready, bit0 run).
- Single module. The watchdog is a natural sub-module, spi1_bus_watchdog, instantiated only under the macro.

Test Plan:
- Write frame 0x40,0x03,0xE8,0x0F → one request: addr 0x0E80F, we=1, data 0x03; pointer becomes 0x0E810 after ack.
- Read frame 0xC1,0xFF,0xFF with ack data 0x5A → read at 0x1FFFF, tx_data_o=0x5A, tx_valid_o=1. A following frame 0x80 then reads 0x00000 (wrap).
- Frame 0x40,0x77 then cs_active_i falls → no bus_req_o; pointer unchanged.
- Read frame 0x80, ack delayed 10 cycles, extra byte 0xAA arrives meanwhile → err_overrun_o=1, exactly one request; err_overrun_o clears at the next cs_active_i rise.
- reset_i asserted during REQ → bus_req_o=0 next cycle; all outputs at reset values.
- With SPI1_CMD_TIMEOUT_EN and no ack → bus_req_o drops after 255 cycles, err_timeout_o=1, pointer unchanged.

Source files
------------

// File: rtl/spi1_pkg.sv
// spi1_pkg: shared constants and types for the SPI1 command sequencer.
// Holds command-byte layout, address width, FSM states and PET register map.
package spi1_pkg;

    localparam int ADDR_WIDTH = 17;

    localparam int CMD_RW_N_BIT     = 7;
    localparam int CMD_SET_ADDR_BIT = 6;
    localparam int CMD_A16_BIT      = 0;

    localparam logic [16:0] PET_CPU_CTL_ADDR  = 17'h0E80F;
    localparam int          PET_CPU_READY_BIT = 1;
    localparam int          PET_CPU_RUN_BIT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_REQ,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/spi1_bus_watchdog.sv
// spi1_bus_watchdog: counts cycles while a bus request is outstanding.
// Only built into spi1_cmd_ctl when SPI1_CMD_TIMEOUT_EN is defined.
module spi1_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Cycle counter, restarted whenever the request is not pending
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires in the TIMEOUT_CYCLES-th cycle of the pending request
    assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/spi1_cmd_ctl.sv
// spi1_cmd_ctl: SPI1 target command sequencer (frame parse + bus requests).
// Optional bus-ack watchdog enabled by defining SPI1_CMD_TIMEOUT_EN.
module spi1_cmd_ctl
    import spi1_pkg::*;
#(
    parameter int ADDR_WIDTH     = spi1_pkg::ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_sys_i,
    input  logic                  reset_i,
    input  logic                  cs_active_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [7:0]            bus_wr_data_o,
    input  logic [7:0]            bus_rd_data_i,
    input  logic                  bus_ack_i,
    output logic                  busy_o,
    output logic                  err_overrun_o,
    output logic                  err_timeout_o
);

    state_t state, state_nx;

    logic                  cs_q;
    logic                  cs_rise;
    logic                  rx_ok;
    logic                  we_q;
    logic                  set_addr_q;
    logic                  a16_q;
    logic [7:0]            hi_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [7:0]            wr_data_q;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  ovr_q;
    logic                  tmo_q;
    logic                  wdt_expired;

    assign cs_rise = cs_active_i && !cs_q;
    // A byte arriving together with a chip-select fall is discarded
    assign rx_ok   = rx_valid_i && cs_active_i;

`ifdef SPI1_CMD_TIMEOUT_EN
    spi1_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk_sys_i),
        .reset  (reset_i),
        .run    (state == ST_REQ),
        .expired(wdt_expired)
    );
`else
    // No watchdog: a pending request waits for the ack forever
    assign wdt_expired = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; chip-select loss aborts any unfinished frame
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (cs_rise) state_nx = ST_CMD;
            end
            ST_CMD: begin
                if (!cs_active_i) begin
                    state_nx = ST_IDLE;
                end else if (rx_ok) begin
                    if (!rx_data_i[CMD_RW_N_BIT]) begin
                        state_nx = ST_DATA;
                    end else if (rx_data_i[CMD_SET_ADDR_BIT]) begin
                        state_nx = ST_ADDR_HI;
                    end else begin
                        state_nx = ST_REQ;
                    end
                end
            end
            ST_DATA: begin
                if (!cs_active_i) begin
                    state_nx = ST_IDLE;
                end else if (rx_ok) begin
                    state_nx = set_addr_q ? ST_ADDR_HI : ST_REQ;
                end
            end
            ST_ADDR_HI: begin
                if (!cs_active_i)  state_nx = ST_IDLE;
                else if (rx_ok)    state_nx = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
                if (!cs_active_i)  state_nx = ST_IDLE;
                else if (rx_ok)    state_nx = ST_REQ;
            end
            ST_REQ: begin
                if (bus_ack_i || wdt_expired) begin
                    state_nx = cs_active_i ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!cs_active_i) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output decode from state and datapath registers
    always_comb begin
        busy_o        = (state != ST_IDLE);
        bus_req_o     = (state == ST_REQ);
        bus_we_o      = we_q;
        bus_addr_o    = ptr_q;
        bus_wr_data_o = wr_data_q;
        tx_data_o     = tx_data_q;
        tx_valid_o    = tx_valid_q;
        err_overrun_o = ovr_q;
        err_timeout_o = tmo_q;
    end

    // Frame fields, address pointer, read result and sticky error flags
    always_ff @(posedge clk_sys_i) begin
        if (reset_i) begin
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            set_addr_q <= 1'b0;
            a16_q      <= 1'b0;
            hi_q       <= '0;
            ptr_q      <= '0;
            wr_data_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            cs_q <= cs_active_i;
            unique case (state)
                ST_IDLE: begin
                    if (cs_rise) begin
                        tx_valid_q <= 1'b0;
                        ovr_q      <= 1'b0;
                        tmo_q      <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (rx_ok) begin
                        we_q       <= !rx_data_i[CMD_RW_N_BIT];
                        set_addr_q <= rx_data_i[CMD_SET_ADDR_BIT];
                        a16_q      <= rx_data_i[CMD_A16_BIT];
                    end
                end
                ST_DATA: begin
                    if (rx_ok) wr_data_q <= rx_data_i;
                end
                ST_ADDR_HI: begin
                    if (rx_ok) hi_q <= rx_data_i;
                end
                ST_ADDR_LO: begin
                    if (rx_ok) ptr_q <= ADDR_WIDTH'({a16_q, hi_q, rx_data_i});
                end
                ST_REQ: begin
                    if (bus_ack_i) begin
                        ptr_q <= ptr_q + ADDR_WIDTH'(1);
                        if (!we_q) begin
                            tx_data_q  <= bus_rd_data_i;
                            tx_valid_q <= 1'b1;
                        end
                    end else if (wdt_expired) begin
                        tmo_q <= 1'b1;
                    end
                    if (rx_ok) ovr_q <= 1'b1;
                end
                ST_DRAIN: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule
